// File: rtl/ipgen_memory_arbiter.sv
// ipgen_memory_arbiter: shares one downstream master memory port among NUM_REQ
// requesters. Write (AW+W) and read (AR+R) channels are arbitrated independently,
// round-robin, with the grant locked for the duration of a burst.
module ipgen_memory_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               CLK,
  input  logic                               RST,
  // requester write address
  input  logic [NUM_REQ-1:0]                 s_awvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      s_awaddr,
  input  logic [NUM_REQ*8-1:0]               s_awlen,
  output logic [NUM_REQ-1:0]                 s_awready,
  // requester write data
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      s_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  s_wstrb,
  input  logic [NUM_REQ-1:0]                 s_wlast,
  input  logic [NUM_REQ-1:0]                 s_wvalid,
  output logic [NUM_REQ-1:0]                 s_wready,
  // requester read address
  input  logic [NUM_REQ-1:0]                 s_arvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      s_araddr,
  input  logic [NUM_REQ*8-1:0]               s_arlen,
  output logic [NUM_REQ-1:0]                 s_arready,
  // requester read data (data/last broadcast, valid per requester)
  output logic [DATA_WIDTH-1:0]              s_rdata,
  output logic                               s_rlast,
  output logic [NUM_REQ-1:0]                 s_rvalid,
  input  logic [NUM_REQ-1:0]                 s_rready,
  // downstream write address
  output logic                               m_awvalid,
  output logic [ADDR_WIDTH-1:0]              m_awaddr,
  output logic [7:0]                         m_awlen,
  input  logic                               m_awready,
  // downstream write data
  output logic [DATA_WIDTH-1:0]              m_wdata,
  output logic [DATA_WIDTH/8-1:0]            m_wstrb,
  output logic                               m_wlast,
  output logic                               m_wvalid,
  input  logic                               m_wready,
  // downstream read address
  output logic                               m_arvalid,
  output logic [ADDR_WIDTH-1:0]              m_araddr,
  output logic [7:0]                         m_arlen,
  input  logic                               m_arready,
  // downstream read data
  input  logic [DATA_WIDTH-1:0]              m_rdata,
  input  logic                               m_rlast,
  input  logic                               m_rvalid,
  output logic                               m_rready
);

  localparam int          GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          SW = DATA_WIDTH / 8;
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  w_state_e        w_state_q, w_state_d;
  logic [GW-1:0]   wgnt_q, wgnt_d;
  logic [GW-1:0]   wlast_q, wlast_d;
  logic [7:0]      wcnt_q, wcnt_d;
  r_state_e        r_state_q, r_state_d;
  logic [GW-1:0]   rgnt_q, rgnt_d;
  logic [GW-1:0]   rlast_q, rlast_d;

  // m_wlast is regenerated from the beat counter, so requester wlast is not used
  logic unused_s_wlast;
  assign unused_s_wlast = ^s_wlast;

  // first requesting index after the previous winner, wrapping around
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [GW-1:0] last);
    logic [GW-1:0] pick;
    logic          found;
    int unsigned   idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NR; i++) begin
      idx = (int'(last) + i) % NR;
      if (!found && req[GW'(idx)]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // write channel next-state: grant, address handshake, beat countdown
  always_comb begin
    w_state_d = w_state_q;
    wgnt_d    = wgnt_q;
    wlast_d   = wlast_q;
    wcnt_d    = wcnt_q;
    case (w_state_q)
      W_IDLE: if (|s_awvalid) begin
        wgnt_d    = rr_pick(s_awvalid, wlast_q);
        w_state_d = W_ADDR;
      end
      W_ADDR: if (s_awvalid[wgnt_q] && m_awready) begin
        wcnt_d    = s_awlen[int'(wgnt_q)*8 +: 8];
        w_state_d = W_DATA;
      end
      W_DATA: if (m_wvalid && m_wready) begin
        if (wcnt_q == '0) begin
          wlast_d   = wgnt_q;
          w_state_d = W_IDLE;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // read channel next-state: completion follows downstream rlast
  always_comb begin
    r_state_d = r_state_q;
    rgnt_d    = rgnt_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: if (|s_arvalid) begin
        rgnt_d    = rr_pick(s_arvalid, rlast_q);
        r_state_d = R_ADDR;
      end
      R_ADDR: if (s_arvalid[rgnt_q] && m_arready) r_state_d = R_DATA;
      R_DATA: if (m_rvalid && m_rready && m_rlast) begin
        rlast_d   = rgnt_q;
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // channel muxing: only the granted requester is connected in each phase
  always_comb begin
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awlen   = '0;
    s_awready = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    s_wready  = '0;
    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_arlen   = '0;
    s_arready = '0;
    s_rvalid  = '0;
    s_rdata   = '0;
    s_rlast   = 1'b0;
    m_rready  = 1'b0;
    if (w_state_q == W_ADDR) begin
      m_awvalid         = s_awvalid[wgnt_q];
      m_awaddr          = s_awaddr[int'(wgnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
      m_awlen           = s_awlen[int'(wgnt_q)*8 +: 8];
      s_awready[wgnt_q] = m_awready;
    end
    if (w_state_q == W_DATA) begin
      m_wvalid         = s_wvalid[wgnt_q];
      m_wdata          = s_wdata[int'(wgnt_q)*DATA_WIDTH +: DATA_WIDTH];
      m_wstrb          = s_wstrb[int'(wgnt_q)*SW +: SW];
      m_wlast          = (wcnt_q == '0);
      s_wready[wgnt_q] = m_wready;
    end
    if (r_state_q == R_ADDR) begin
      m_arvalid         = s_arvalid[rgnt_q];
      m_araddr          = s_araddr[int'(rgnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
      m_arlen           = s_arlen[int'(rgnt_q)*8 +: 8];
      s_arready[rgnt_q] = m_arready;
    end
    if (r_state_q == R_DATA) begin
      s_rvalid[rgnt_q] = m_rvalid;
      s_rdata          = m_rdata;
      s_rlast          = m_rlast;
      m_rready         = s_rready[rgnt_q];
    end
  end

  // state registers; reset makes requester 0 the first winner on both channels
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_state_q <= W_IDLE;
      wgnt_q    <= '0;
      wlast_q   <= GW'(NUM_REQ - 1);
      wcnt_q    <= '0;
      r_state_q <= R_IDLE;
      rgnt_q    <= '0;
      rlast_q   <= GW'(NUM_REQ - 1);
    end else begin
      w_state_q <= w_state_d;
      wgnt_q    <= wgnt_d;
      wlast_q   <= wlast_d;
      wcnt_q    <= wcnt_d;
      r_state_q <= r_state_d;
      rgnt_q    <= rgnt_d;
      rlast_q   <= rlast_d;
    end
  end

endmodule

// File: tb/tb_ipgen_memory_arbiter.sv
// Bench for ipgen_memory_arbiter: requester and downstream memory models drive
// traffic; a burst-level model predicts grants, routing and beat contents.
module tb_ipgen_memory_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int P_IDLE = 0, P_ADDR = 1, P_DATA = 2;

  logic CLK, RST;
  logic [N-1:0]    s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic [N*AW-1:0] s_awaddr, s_araddr;
  logic [N*8-1:0]  s_awlen, s_arlen;
  logic [N*DW-1:0] s_wdata;
  logic [N*SW-1:0] s_wstrb;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DW-1:0]   s_rdata;
  logic            s_rlast;
  logic            m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic [AW-1:0]   m_awaddr, m_araddr;
  logic [7:0]      m_awlen, m_arlen;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

  ipgen_memory_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } burst_t;

  // requester-side state: pending bursts and per-requester progress
  burst_t wq [N][$];
  burst_t rq [N][$];
  bit     aw_sent [N];
  bit     ar_sent [N];
  int     wbeat [N];
  int     rbeat [N];

  // burst-level arbitration model, index 0 = write, 1 = read
  int ph [2];
  int gnt [2];
  int lastg [2];
  int beat [2];

  // downstream read memory
  bit            mem_busy;
  logic [AW-1:0] mem_addr;
  int            mem_len, mem_beat;

  // handshakes observed before the clock edge, applied after it
  logic [N-1:0]  aw_hs_v, w_hs_v, ar_hs_v, r_hs_v;
  logic          m_ar_hs, m_r_hs;
  logic [AW-1:0] cap_araddr;
  logic [7:0]    cap_arlen;

  int  rdy_pct, val_pct;
  bit  wrdy_toggle, wrdy_ph;
  int  n_cmp, n_bad;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] wdata_f(input int i, input logic [AW-1:0] a, input int k);
    return a ^ {8'(i + 1), 8'(k), 16'(k * 257)};
  endfunction

  function automatic logic [SW-1:0] wstrb_f(input int i, input logic [AW-1:0] a, input int k);
    return SW'(a[3:0] ^ 4'(k) ^ 4'(i * 5));
  endfunction

  function automatic logic [DW-1:0] rdata_f(input logic [AW-1:0] a, input int k);
    return ~a + DW'(k * 3);
  endfunction

  // round robin: first requester after the last winner, wrapping
  function automatic int rr(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return last;
  endfunction

  function automatic bit rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic int pending_count();
    int c;
    c = mem_busy + (ph[0] != P_IDLE) + (ph[1] != P_IDLE);
    for (int i = 0; i < N; i++) c += wq[i].size() + rq[i].size();
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      wq[i].delete(); rq[i].delete();
      aw_sent[i] = 0; ar_sent[i] = 0; wbeat[i] = 0; rbeat[i] = 0;
    end
    for (int c = 0; c < 2; c++) begin
      ph[c] = P_IDLE; gnt[c] = 0; lastg[c] = N - 1; beat[c] = 0;
    end
    mem_busy = 0; mem_addr = '0; mem_len = 0; mem_beat = 0;
  endtask

  task automatic drive();
    burst_t b;
    for (int i = 0; i < N; i++) begin
      s_awvalid[i] = 1'b0; s_awaddr[i*AW +: AW] = '0; s_awlen[i*8 +: 8] = '0;
      s_wvalid[i] = 1'b0; s_wdata[i*DW +: DW] = '0; s_wstrb[i*SW +: SW] = '0;
      s_wlast[i] = 1'($urandom_range(0, 1));
      if (wq[i].size() > 0) begin
        b = wq[i][0];
        s_awvalid[i]          = !aw_sent[i];
        s_awaddr[i*AW +: AW]  = b.addr;
        s_awlen[i*8 +: 8]     = b.len;
        s_wvalid[i]           = rnd(val_pct);
        s_wdata[i*DW +: DW]   = wdata_f(i, b.addr, wbeat[i]);
        s_wstrb[i*SW +: SW]   = wstrb_f(i, b.addr, wbeat[i]);
      end
      s_arvalid[i] = 1'b0; s_araddr[i*AW +: AW] = '0; s_arlen[i*8 +: 8] = '0;
      if (rq[i].size() > 0) begin
        b = rq[i][0];
        s_arvalid[i]         = !ar_sent[i];
        s_araddr[i*AW +: AW] = b.addr;
        s_arlen[i*8 +: 8]    = b.len;
      end
      s_rready[i] = rnd(val_pct);
    end
    m_awready = rnd(rdy_pct);
    if (wrdy_toggle) begin
      m_wready = wrdy_ph;
      wrdy_ph  = !wrdy_ph;
    end else begin
      m_wready = rnd(rdy_pct);
    end
    m_arready = rnd(rdy_pct);
    m_rvalid  = mem_busy && rnd(rdy_pct);
    m_rdata   = rdata_f(mem_addr, mem_beat);
    m_rlast   = mem_busy && (mem_beat == mem_len);
  endtask

  // compare DUT outputs with the burst model, then advance the model
  task automatic observe();
    logic [N-1:0] oh;
    burst_t b;
    int g, pw, pr;
    pw = ph[0]; pr = ph[1];
    aw_hs_v = s_awvalid & s_awready; w_hs_v = s_wvalid & s_wready;
    ar_hs_v = s_arvalid & s_arready; r_hs_v = s_rvalid & s_rready;
    m_ar_hs = m_arvalid & m_arready; m_r_hs = m_rvalid & m_rready;
    cap_araddr = m_araddr; cap_arlen = m_arlen;

    g = gnt[0]; oh = N'(1) << g; b = wq[g][0];
    if (pw == P_ADDR) begin
      check_eq("m_awvalid", m_awvalid, 1);
      check_eq("m_awaddr", m_awaddr, b.addr);
      check_eq("m_awlen", m_awlen, b.len);
      check_eq("s_awready", s_awready, m_awready ? oh : '0);
      if (m_awvalid && m_awready) begin ph[0] = P_DATA; beat[0] = 0; end
    end else begin
      check_eq("m_awvalid_off", m_awvalid, 0);
      check_eq("s_awready_off", s_awready, 0);
      if (pw == P_IDLE && |s_awvalid) begin
        gnt[0] = rr(lastg[0], s_awvalid); ph[0] = P_ADDR;
      end
    end
    if (pw == P_DATA) begin
      check_eq("m_wvalid", m_wvalid, s_wvalid[g]);
      check_eq("s_wready", s_wready, m_wready ? oh : '0);
      if (m_wvalid && m_wready) begin
        check_eq("m_wdata", m_wdata, wdata_f(g, b.addr, beat[0]));
        check_eq("m_wstrb", m_wstrb, wstrb_f(g, b.addr, beat[0]));
        check_eq("m_wlast", m_wlast, beat[0] == int'(b.len));
        if (beat[0] == int'(b.len)) begin ph[0] = P_IDLE; lastg[0] = g; end
        else beat[0]++;
      end
    end else begin
      check_eq("m_wvalid_off", m_wvalid, 0);
      check_eq("s_wready_off", s_wready, 0);
    end

    g = gnt[1]; oh = N'(1) << g; b = rq[g][0];
    if (pr == P_ADDR) begin
      check_eq("m_arvalid", m_arvalid, 1);
      check_eq("m_araddr", m_araddr, b.addr);
      check_eq("m_arlen", m_arlen, b.len);
      check_eq("s_arready", s_arready, m_arready ? oh : '0);
      if (m_arvalid && m_arready) begin ph[1] = P_DATA; beat[1] = 0; end
    end else begin
      check_eq("m_arvalid_off", m_arvalid, 0);
      check_eq("s_arready_off", s_arready, 0);
      if (pr == P_IDLE && |s_arvalid) begin
        gnt[1] = rr(lastg[1], s_arvalid); ph[1] = P_ADDR;
      end
    end
    if (pr == P_DATA) begin
      check_eq("s_rvalid", s_rvalid, m_rvalid ? oh : '0);
      check_eq("m_rready", m_rready, s_rready[g]);
      if (m_rvalid && m_rready) begin
        check_eq("s_rdata", s_rdata, rdata_f(b.addr, beat[1]));
        check_eq("s_rlast", s_rlast, beat[1] == int'(b.len));
        if (m_rlast) begin ph[1] = P_IDLE; lastg[1] = g; end
        else beat[1]++;
      end
    end else begin
      check_eq("s_rvalid_off", s_rvalid, 0);
      check_eq("m_rready_off", m_rready, 0);
    end
  endtask

  // requester and memory progress from the handshakes of the last edge
  task automatic update();
    for (int i = 0; i < N; i++) begin
      if (aw_hs_v[i]) aw_sent[i] = 1;
      if (w_hs_v[i] && wq[i].size() > 0) begin
        wbeat[i]++;
        if (wbeat[i] > int'(wq[i][0].len)) begin
          wq[i].delete(0); wbeat[i] = 0; aw_sent[i] = 0;
        end
      end
      if (ar_hs_v[i]) ar_sent[i] = 1;
      if (r_hs_v[i] && rq[i].size() > 0) begin
        rbeat[i]++;
        if (rbeat[i] > int'(rq[i][0].len)) begin
          rq[i].delete(0); rbeat[i] = 0; ar_sent[i] = 0;
        end
      end
    end
    if (m_r_hs && mem_busy) begin
      if (mem_beat == mem_len) mem_busy = 0;
      else mem_beat++;
    end
    if (m_ar_hs) begin
      mem_busy = 1; mem_addr = cap_araddr; mem_len = int'(cap_arlen); mem_beat = 0;
    end
  endtask

  task automatic step();
    @(negedge CLK);
    observe();
    @(posedge CLK);
    #1;
    update();
    drive();
  endtask

  task automatic run_idle(input int maxc);
    int c;
    c = 0;
    while (pending_count() != 0 && c < maxc) begin step(); c++; end
    check_eq("drain", pending_count(), 0);
    repeat (3) step();
  endtask

  // async reset: valid/ready outputs must drop immediately; released just after an edge
  task automatic do_reset();
    RST = 1'b1;
    #1;
    check_eq("rst_valid_ready",
             {m_awvalid, m_wvalid, m_arvalid, m_rready, s_awready, s_wready, s_arready, s_rvalid}, '0);
    model_reset();
    drive();
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_mux_data", {m_awaddr, m_awlen, m_araddr, m_arlen}, '0);
    check_eq("rst_wdata", {m_wdata, m_wstrb, m_wlast, s_rdata, s_rlast}, '0);
    RST = 1'b0;
  endtask

  task automatic push_w(input int i, input logic [AW-1:0] a, input int len);
    burst_t b;
    b.addr = a; b.len = 8'(len);
    wq[i].push_back(b);
  endtask

  task automatic push_r(input int i, input logic [AW-1:0] a, input int len);
    burst_t b;
    b.addr = a; b.len = 8'(len);
    rq[i].push_back(b);
  endtask

  initial begin
    int c, i;
    n_cmp = 0; n_bad = 0;
    rdy_pct = 100; val_pct = 100; wrdy_toggle = 0; wrdy_ph = 1;
    RST = 1'b1;
    model_reset();
    drive();
    do_reset();

    // single 4-beat write, everything ready
    push_w(0, 32'h100, 3);
    drive();
    run_idle(100);

    // two requesters, back-to-back single-beat bursts alternate from requester 0
    do_reset();
    push_w(0, 32'h1000, 0); push_w(0, 32'h1010, 0);
    push_w(1, 32'h2000, 0); push_w(1, 32'h2010, 0);
    drive();
    run_idle(100);

    // long write with a concurrent short read from another requester
    push_w(0, 32'h3000, 7);
    push_r(1, 32'h4000, 0);
    drive();
    run_idle(100);

    // maximum length burst; requester wlast is random noise
    push_w(2, 32'h5000, 255);
    drive();
    run_idle(400);

    // alternating downstream wready while another requester keeps wvalid high
    wrdy_toggle = 1;
    push_w(0, 32'h6000, 5);
    push_w(1, 32'h7000, 2);
    drive();
    run_idle(200);
    wrdy_toggle = 0;

    // randomized mixed traffic
    rdy_pct = 70; val_pct = 75;
    for (int n = 0; n < 700; n++) begin
      step();
      if (rnd(10)) begin
        i = $urandom_range(0, N - 1);
        c = rnd(10) ? int'($urandom_range(4, 24)) : int'($urandom_range(0, 3));
        if (rnd(50)) begin
          if (wq[i].size() < 3) push_w(i, $urandom, c);
        end else begin
          if (rq[i].size() < 3) push_r(i, $urandom, c);
        end
      end
    end
    run_idle(3000);

    // reset in the middle of a 4-beat read, then a fresh simultaneous request
    rdy_pct = 100; val_pct = 100;
    push_r(1, 32'h8000, 3);
    drive();
    c = 0;
    while (!(ph[1] == P_DATA && beat[1] == 2) && c < 100) begin step(); c++; end
    check_eq("read_reaches_beat2", beat[1], 2);
    do_reset();
    push_r(0, 32'h9000, 0); push_r(1, 32'h9100, 0);
    push_w(0, 32'hA000, 1); push_w(1, 32'hA100, 1);
    drive();
    run_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
